// File: rtl/mixn_if.sv
// Sample/config bus for the multi-channel DDC mixer.
// The master drives ADC samples and tuning words; the slave (mixn) returns I/Q.
interface mixn_if #(
  parameter int NCHAN   = 2,
  parameter int ADC_W   = 12,
  parameter int OUT_W   = 18,
  parameter int PHASE_W = 32
);
  localparam int CW = (NCHAN > 1) ? $clog2(NCHAN) : 1;

  logic                     adc_valid;
  logic signed [ADC_W-1:0]  adc;
  logic                     sync;
  logic                     cfg_we;
  logic [CW-1:0]            cfg_chan;
  logic [PHASE_W-1:0]       cfg_inc;
  logic                     out_valid;
  logic [NCHAN*OUT_W-1:0]   i_data;
  logic [NCHAN*OUT_W-1:0]   q_data;

  modport master (
    output adc_valid, adc, sync, cfg_we, cfg_chan, cfg_inc,
    input  out_valid, i_data, q_data
  );

  modport slave (
    input  adc_valid, adc, sync, cfg_we, cfg_chan, cfg_inc,
    output out_valid, i_data, q_data
  );
endinterface

// File: rtl/mixn.sv
// Multi-channel DDC mixer: per-channel NCO (phase accumulator + quarter-wave LUT)
// multiplying a shared ADC stream, with round-half-up and saturation on the output.
// Pipeline: S0 capture, S1 ROM read, S2 quadrant sign, S3 multiply, S4 round -> out.
module mixn #(
  parameter int NCHAN   = 2,
  parameter int ADC_W   = 12,
  parameter int NCO_W   = 18,
  parameter int OUT_W   = 18,
  parameter int PHASE_W = 32,
  parameter int LUT_AW  = 10
) (
  input logic   clk,
  input logic   rst,
  mixn_if.slave bus
);
  localparam int  PW    = ADC_W + NCO_W;
  localparam int  ROM_N = 2 ** LUT_AW;
  localparam int  CW    = (NCHAN > 1) ? $clog2(NCHAN) : 1;
  localparam int  TW    = LUT_AW + 2;  // phase bits that actually address the LUT
  localparam real PI    = 3.14159265358979323846;
  localparam real PEAK  = real'((2 ** (NCO_W - 1)) - 1);

  // Quarter-wave table sampled at half-step offsets, so no entry is ever zero.
  logic [NCO_W-2:0] rom [ROM_N];
  for (genvar k = 0; k < ROM_N; k++) begin : g_rom
    localparam real Ang = PI / 2.0 * (real'(k) + 0.5) / real'(ROM_N);
    localparam int  Val = $rtoi(PEAK * $sin(Ang) + 0.5);
    assign rom[k] = (NCO_W - 1)'(Val);
  end

  logic [PHASE_W-1:0]       acc_q [NCHAN];
  logic [PHASE_W-1:0]       acc_d [NCHAN];
  logic [PHASE_W-1:0]       inc_q [NCHAN];
  logic [PHASE_W-1:0]       inc_d [NCHAN];
  logic [4:0]               v_q, v_d;
  logic signed [ADC_W-1:0]  adc0_q, adc0_d, adc1_q, adc1_d, adc2_q, adc2_d;
  logic [TW-1:0]            ph0_q [NCHAN];
  logic [TW-1:0]            ph0_d [NCHAN];
  logic [1:0]               quad1_q [NCHAN];
  logic [1:0]               quad1_d [NCHAN];
  logic [NCO_W-2:0]         rom_a1_q [NCHAN];
  logic [NCO_W-2:0]         rom_a1_d [NCHAN];
  logic [NCO_W-2:0]         rom_b1_q [NCHAN];
  logic [NCO_W-2:0]         rom_b1_d [NCHAN];
  logic signed [NCO_W-1:0]  sin2_q [NCHAN];
  logic signed [NCO_W-1:0]  sin2_d [NCHAN];
  logic signed [NCO_W-1:0]  cos2_q [NCHAN];
  logic signed [NCO_W-1:0]  cos2_d [NCHAN];
  logic signed [PW-1:0]     mul_i [NCHAN];
  logic signed [PW-1:0]     mul_q [NCHAN];
  logic [PW-2:0]            prod_i3_q [NCHAN];
  logic [PW-2:0]            prod_i3_d [NCHAN];
  logic [PW-2:0]            prod_q3_q [NCHAN];
  logic [PW-2:0]            prod_q3_d [NCHAN];
  logic [OUT_W-1:0]         rnd_i [NCHAN];
  logic [OUT_W-1:0]         rnd_q [NCHAN];
  logic [NCHAN*OUT_W-1:0]   i_q, i_d, q_q, q_d;
  logic                     unused_mul_top;

  // Tuning words and phase accumulators; the accumulator always uses the pre-edge inc.
  always_comb begin
    for (int c = 0; c < NCHAN; c++) begin
      inc_d[c] = inc_q[c];
      if (bus.cfg_we && bus.cfg_chan == CW'(c)) inc_d[c] = bus.cfg_inc;
      acc_d[c] = acc_q[c];
      if (bus.sync)           acc_d[c] = bus.adc_valid ? inc_q[c] : '0;
      else if (bus.adc_valid) acc_d[c] = acc_q[c] + inc_q[c];
    end
  end

  // S0: capture the sample and each channel's phase; sync forces phase 0.
  always_comb begin
    v_d    = {v_q[3:0], bus.adc_valid};
    adc0_d = bus.adc_valid ? bus.adc : adc0_q;
    for (int c = 0; c < NCHAN; c++) begin
      ph0_d[c] = ph0_q[c];
      if (bus.adc_valid) ph0_d[c] = bus.sync ? '0 : acc_q[c][PHASE_W-1 -: TW];
    end
  end

  // S1: read the table at idx and at its mirror ~idx.
  always_comb begin
    logic [LUT_AW-1:0] idx;
    idx    = '0;
    adc1_d = adc0_q;
    for (int c = 0; c < NCHAN; c++) begin
      idx         = ph0_q[c][LUT_AW-1:0];
      quad1_d[c]  = ph0_q[c][TW-1 -: 2];
      rom_a1_d[c] = rom[idx];
      rom_b1_d[c] = rom[~idx];
    end
  end

  // S2: rebuild full-wave sin/cos from the quadrant.
  always_comb begin
    logic signed [NCO_W-1:0] pa, pb;
    pa     = '0;
    pb     = '0;
    adc2_d = adc1_q;
    for (int c = 0; c < NCHAN; c++) begin
      pa = {1'b0, rom_a1_q[c]};
      pb = {1'b0, rom_b1_q[c]};
      unique case (quad1_q[c])
        2'd0:    begin sin2_d[c] =  pa; cos2_d[c] =  pb; end
        2'd1:    begin sin2_d[c] =  pb; cos2_d[c] = -pa; end
        2'd2:    begin sin2_d[c] = -pa; cos2_d[c] = -pb; end
        default: begin sin2_d[c] = -pb; cos2_d[c] =  pa; end
      endcase
    end
  end

  // S3: full signed product; the top bit is redundant since the NCO never hits -2^(NCO_W-1).
  always_comb begin
    unused_mul_top = 1'b0;
    for (int c = 0; c < NCHAN; c++) begin
      mul_i[c]     = PW'(adc2_q) * PW'(cos2_q[c]);
      mul_q[c]     = PW'(adc2_q) * PW'(sin2_q[c]);
      prod_i3_d[c] = mul_i[c][PW-2:0];
      prod_q3_d[c] = mul_q[c][PW-2:0];
      unused_mul_top = unused_mul_top ^ mul_i[c][PW-1] ^ mul_q[c][PW-1];
    end
  end

  if (OUT_W >= PW - 1) begin : g_wide
    // Whole product fits: left-justify, zero-fill, no rounding.
    always_comb begin
      for (int c = 0; c < NCHAN; c++) begin
        rnd_i[c] = OUT_W'(prod_i3_q[c]) << (OUT_W - PW + 1);
        rnd_q[c] = OUT_W'(prod_q3_q[c]) << (OUT_W - PW + 1);
      end
    end
  end else begin : g_round
    localparam int RB = PW - 2 - OUT_W;  // first bit below the kept field

    function automatic logic [OUT_W-1:0] rsat(input logic [PW-2:0] p);
      logic signed [OUT_W:0] s;
      logic                  unused_lo;
      unused_lo = ^p;
      s = $signed({p[PW-2], p[PW-2 -: OUT_W]}) + $signed((OUT_W + 1)'(p[RB]));
      if (s[OUT_W] != s[OUT_W-1]) begin
        rsat = s[OUT_W] ? {1'b1, {(OUT_W - 1){1'b0}}} : {1'b0, {(OUT_W - 1){1'b1}}};
      end else begin
        rsat = s[OUT_W-1:0];
      end
    endfunction

    // Round half-up, clamp instead of wrapping.
    always_comb begin
      for (int c = 0; c < NCHAN; c++) begin
        rnd_i[c] = rsat(prod_i3_q[c]);
        rnd_q[c] = rsat(prod_q3_q[c]);
      end
    end
  end

  // S4: outputs load only for a valid sample and hold otherwise.
  always_comb begin
    i_d = i_q;
    q_d = q_q;
    if (v_q[3]) begin
      for (int c = 0; c < NCHAN; c++) begin
        i_d[c*OUT_W +: OUT_W] = rnd_i[c];
        q_d[c*OUT_W +: OUT_W] = rnd_q[c];
      end
    end
  end

  // All state; reset drops samples in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NCHAN; c++) begin
        acc_q[c]     <= '0;
        inc_q[c]     <= '0;
        ph0_q[c]     <= '0;
        quad1_q[c]   <= '0;
        rom_a1_q[c]  <= '0;
        rom_b1_q[c]  <= '0;
        sin2_q[c]    <= '0;
        cos2_q[c]    <= '0;
        prod_i3_q[c] <= '0;
        prod_q3_q[c] <= '0;
      end
      v_q    <= '0;
      adc0_q <= '0;
      adc1_q <= '0;
      adc2_q <= '0;
      i_q    <= '0;
      q_q    <= '0;
    end else begin
      acc_q     <= acc_d;
      inc_q     <= inc_d;
      ph0_q     <= ph0_d;
      quad1_q   <= quad1_d;
      rom_a1_q  <= rom_a1_d;
      rom_b1_q  <= rom_b1_d;
      sin2_q    <= sin2_d;
      cos2_q    <= cos2_d;
      prod_i3_q <= prod_i3_d;
      prod_q3_q <= prod_q3_d;
      v_q       <= v_d;
      adc0_q    <= adc0_d;
      adc1_q    <= adc1_d;
      adc2_q    <= adc2_d;
      i_q       <= i_d;
      q_q       <= q_d;
    end
  end

  assign bus.out_valid = v_q[4];
  assign bus.i_data    = i_q;
  assign bus.q_data    = q_q;
endmodule

// File: tb/tb_mixn.sv
// Directed bench for mixn: default instance plus a 3-channel, 12-bit-output instance
// for the out-of-range cfg_chan and saturation cases.
module tb_mixn;
  localparam int OW  = 18;
  localparam int OWN = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mixn_if #(.NCHAN(2), .ADC_W(12), .OUT_W(OW),  .PHASE_W(32)) b0 ();
  mixn_if #(.NCHAN(3), .ADC_W(12), .OUT_W(OWN), .PHASE_W(32)) b1 ();

  mixn #(.NCHAN(2), .OUT_W(OW))  dut   (.clk(clk), .rst(rst), .bus(b0));
  mixn #(.NCHAN(3), .OUT_W(OWN)) dut_n (.clk(clk), .rst(rst), .bus(b1));

  int checks = 0;
  int passed = 0;

  function automatic logic signed [OW-1:0] i0(input int c);
    return b0.i_data[c*OW +: OW];
  endfunction
  function automatic logic signed [OW-1:0] q0(input int c);
    return b0.q_data[c*OW +: OW];
  endfunction
  function automatic logic signed [OWN-1:0] i1(input int c);
    return b1.i_data[c*OWN +: OWN];
  endfunction
  function automatic logic signed [OWN-1:0] q1(input int c);
    return b1.q_data[c*OWN +: OWN];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    b0.adc_valid = 1'b0; b0.sync = 1'b0; b0.cfg_we = 1'b0;
    b1.adc_valid = 1'b0; b1.sync = 1'b0; b1.cfg_we = 1'b0;
  endtask

  task automatic cfg0(input logic ch, input logic [31:0] inc);
    b0.cfg_we = 1'b1; b0.cfg_chan = ch; b0.cfg_inc = inc;
    tick();
    b0.cfg_we = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    b0.adc = '0; b0.cfg_chan = '0; b0.cfg_inc = '0;
    b1.adc = '0; b1.cfg_chan = '0; b1.cfg_inc = '0;
    rst = 1'b1;
    tick();
    checks++; if (b0.out_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", b0.out_valid);
    else passed++;
    checks++; if (b0.i_data !== '0) $display("FAIL reset_i got %h want 0", b0.i_data); else passed++;
    checks++; if (b0.q_data !== '0) $display("FAIL reset_q got %h want 0", b0.q_data); else passed++;
    checks++; if (b1.out_valid !== 1'b0) $display("FAIL reset_valid_n got %b want 0", b1.out_valid);
    else passed++;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_const();
    int n = 0;
    cfg0(1'b0, 32'd0);
    b0.adc = 12'sd2047;
    for (int k = 0; k < 12; k++) begin
      b0.adc_valid = (k < 6);
      b0.sync      = (k == 0);
      tick();
      if (b0.out_valid) begin
        n++;
        checks++; if (i0(0) !== 18'sd131007) $display("FAIL const_i got %0d want 131007", i0(0));
        else passed++;
        checks++; if (q0(0) !== 18'sd101) $display("FAIL const_q got %0d want 101", q0(0));
        else passed++;
      end
    end
    checks++; if (n !== 6) $display("FAIL const_count got %0d want 6", n); else passed++;
    idle();
  endtask

  task automatic test_quarter();
    int ei[4] = '{131007, -101, -131007, 101};
    int eq[4] = '{101, 131007, -101, -131007};
    int n = 0;
    cfg0(1'b0, 32'h4000_0000);
    b0.adc = 12'sd2047;
    for (int k = 0; k < 14; k++) begin
      b0.adc_valid = (k < 8);
      b0.sync      = (k == 0);
      tick();
      if (b0.out_valid) begin
        checks++; if (i0(0) !== 18'(ei[n%4]))
          $display("FAIL quarter_i[%0d] got %0d want %0d", n, i0(0), ei[n%4]); else passed++;
        checks++; if (q0(0) !== 18'(eq[n%4]))
          $display("FAIL quarter_q[%0d] got %0d want %0d", n, q0(0), eq[n%4]); else passed++;
        checks++; if (i0(1) !== 18'sd131007)
          $display("FAIL quarter_ch1_i[%0d] got %0d want 131007", n, i0(1)); else passed++;
        n++;
      end
    end
    checks++; if (n !== 8) $display("FAIL quarter_count got %0d want 8", n); else passed++;
    idle();
  endtask

  task automatic test_latency();
    b0.adc = -12'sd2047;
    b0.adc_valid = 1'b1; b0.sync = 1'b1;
    tick();
    b0.adc_valid = 1'b0; b0.sync = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      checks++; if (b0.out_valid !== 1'(k == 4))
        $display("FAIL latency_valid[+%0d] got %b want %b", k, b0.out_valid, k == 4);
      else passed++;
      if (k >= 4) begin
        checks++; if (i0(0) !== -18'sd131007)
          $display("FAIL latency_i[+%0d] got %0d want -131007", k, i0(0)); else passed++;
        checks++; if (q0(0) !== -18'sd101)
          $display("FAIL latency_q[+%0d] got %0d want -101", k, q0(0)); else passed++;
      end
    end
  endtask

  task automatic test_cfg_same_edge();
    int ei1[4] = '{131007, 131007, -101, -131007};
    int eq1[4] = '{101, 101, 131007, -101};
    int n = 0;
    cfg0(1'b0, 32'd0);
    b0.sync = 1'b1;
    tick();
    b0.sync = 1'b0;
    b0.adc = 12'sd2047;
    b0.cfg_chan = 1'b1; b0.cfg_inc = 32'h4000_0000;
    for (int k = 0; k < 10; k++) begin
      b0.adc_valid = (k < 4);
      b0.cfg_we    = (k == 0);
      tick();
      if (b0.out_valid) begin
        checks++; if (i0(1) !== 18'(ei1[n%4]))
          $display("FAIL cfg_ch1_i[%0d] got %0d want %0d", n, i0(1), ei1[n%4]); else passed++;
        checks++; if (q0(1) !== 18'(eq1[n%4]))
          $display("FAIL cfg_ch1_q[%0d] got %0d want %0d", n, q0(1), eq1[n%4]); else passed++;
        checks++; if (i0(0) !== 18'sd131007)
          $display("FAIL cfg_ch0_i[%0d] got %0d want 131007", n, i0(0)); else passed++;
        n++;
      end
    end
    checks++; if (n !== 4) $display("FAIL cfg_count got %0d want 4", n); else passed++;
    idle();

    // Out-of-range channel on the 3-channel instance must be ignored.
    b1.cfg_we = 1'b1; b1.cfg_chan = 2'd3; b1.cfg_inc = 32'h4000_0000;
    tick();
    b1.cfg_we = 1'b0;
    b1.adc = 12'sd2047;
    n = 0;
    for (int k = 0; k < 9; k++) begin
      b1.adc_valid = (k < 3);
      b1.sync      = (k == 0);
      tick();
      if (b1.out_valid) begin
        for (int c = 0; c < 3; c++) begin
          checks++; if (i1(c) !== 12'sd2047)
            $display("FAIL badchan_i[%0d][ch%0d] got %0d want 2047", n, c, i1(c)); else passed++;
        end
        n++;
      end
    end
    checks++; if (n !== 3) $display("FAIL badchan_count got %0d want 3", n); else passed++;
    idle();
  endtask

  task automatic test_sat();
    int ei[2]  = '{-131071, 131071};
    int eq[2]  = '{-101, 101};
    int eni[2] = '{-2048, 2047};
    int enq[2] = '{-2, 2};
    int n = 0;
    int m = 0;
    b0.cfg_we = 1'b1; b0.cfg_chan = 1'b0; b0.cfg_inc = 32'h8000_0000;
    b1.cfg_we = 1'b1; b1.cfg_chan = 2'd0; b1.cfg_inc = 32'h8000_0000;
    tick();
    b0.cfg_we = 1'b0; b1.cfg_we = 1'b0;
    b0.adc = 12'h800; b1.adc = 12'h800;
    for (int k = 0; k < 10; k++) begin
      b0.adc_valid = (k < 4); b0.sync = (k == 0);
      b1.adc_valid = (k < 4); b1.sync = (k == 0);
      tick();
      if (b0.out_valid) begin
        checks++; if (i0(0) !== 18'(ei[n%2]))
          $display("FAIL sat18_i[%0d] got %0d want %0d", n, i0(0), ei[n%2]); else passed++;
        checks++; if (q0(0) !== 18'(eq[n%2]))
          $display("FAIL sat18_q[%0d] got %0d want %0d", n, q0(0), eq[n%2]); else passed++;
        n++;
      end
      if (b1.out_valid) begin
        checks++; if (i1(0) !== 12'(eni[m%2]))
          $display("FAIL sat12_i[%0d] got %0d want %0d", m, i1(0), eni[m%2]); else passed++;
        checks++; if (q1(0) !== 12'(enq[m%2]))
          $display("FAIL sat12_q[%0d] got %0d want %0d", m, q1(0), enq[m%2]); else passed++;
        m++;
      end
    end
    checks++; if (n !== 4 || m !== 4) $display("FAIL sat_count got %0d/%0d want 4/4", n, m);
    else passed++;
    idle();
  endtask

  task automatic test_reset_mid();
    cfg0(1'b0, 32'h4000_0000);
    b0.adc = 12'sd2047;
    b0.adc_valid = 1'b1; b0.sync = 1'b1;
    tick();
    b0.sync = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    checks++; if (b0.out_valid !== 1'b1) $display("FAIL midrst_pre got %b want 1", b0.out_valid);
    else passed++;
    rst = 1'b1;
    #1;
    checks++; if (b0.out_valid !== 1'b0) $display("FAIL midrst_valid got %b want 0", b0.out_valid);
    else passed++;
    checks++; if (b0.i_data !== '0) $display("FAIL midrst_i got %h want 0", b0.i_data); else passed++;
    checks++; if (b0.q_data !== '0) $display("FAIL midrst_q got %h want 0", b0.q_data); else passed++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      tick();
      checks++; if (b0.out_valid !== 1'(k >= 5))
        $display("FAIL midrst_after[+%0d] got %b want %b", k, b0.out_valid, k >= 5);
      else passed++;
      if (k >= 5) begin
        checks++; if (i0(0) !== 18'sd131007)
          $display("FAIL midrst_i[+%0d] got %0d want 131007", k, i0(0)); else passed++;
        checks++; if (q0(0) !== 18'sd101)
          $display("FAIL midrst_q[+%0d] got %0d want 101", k, q0(0)); else passed++;
      end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_const();
    test_quarter();
    test_latency();
    test_cfg_same_edge();
    test_sat();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
